// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered 8-bit ALU between two requesters.
// Round-robin grant, one operation in flight, illegal ops and divide-by-zero
// are answered with an error response without ever reaching the ALU.
module alu_req_arbiter #(
  parameter int unsigned ALU_LAT = 1,
  parameter logic [3:0]  OP_MAX  = 4'd5,
  parameter logic [3:0]  DIV_OP  = 4'd3
) (
  input  logic        CLK,
  input  logic        Reset,
  // requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req0_cin,
  // requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [3:0]  req1_op,
  input  logic        req1_cin,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        busy,
  // shared ALU
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_zflag
);

  // Counter wide enough to hold ALU_LAT; EXEC runs ALU_LAT+1 cycles by
  // loading ALU_LAT on entry and leaving when it reaches zero.
  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;     // requester granted most recently
  logic             id_q;       // requester owning the in-flight operation

  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic [3:0]       alu_op_q;
  logic             alu_cin_q;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [15:0]      rsp_result_q;
  logic             rsp_cout_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;

  logic             idle_d;
  logic             grant_d;
  logic             accept_d;
  logic             reject_d;
  logic [7:0]       sel_a_d;
  logic [7:0]       sel_b_d;
  logic [3:0]       sel_op_d;
  logic             sel_cin_d;

  assign idle_d = (state_q == IDLE);

  // Grant: a lone valid wins; on a tie the requester not granted last wins.
  // With no valid the pointer still selects one, so exactly one ready is high.
  always_comb begin
    grant_d = ~last_q;
    if (req0_valid && !req1_valid) begin
      grant_d = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant_d = 1'b1;
    end
  end

  assign req0_ready = idle_d && !grant_d && !Reset;
  assign req1_ready = idle_d &&  grant_d && !Reset;

  assign accept_d  = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_a_d   = grant_d ? req1_a   : req0_a;
  assign sel_b_d   = grant_d ? req1_b   : req0_b;
  assign sel_op_d  = grant_d ? req1_op  : req0_op;
  assign sel_cin_d = grant_d ? req1_cin : req0_cin;

  // Ops the ALU must never see: out-of-range op codes and divide by zero.
  assign reject_d  = (sel_op_d > OP_MAX) ||
                     ((sel_op_d == DIV_OP) && (sel_b_d == 8'd0));

  // Control FSM with registered ALU drive and response outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;   // so req0 wins the first tie
      id_q         <= 1'b0;
      alu_a_q      <= 8'd0;
      alu_b_q      <= 8'd0;
      alu_op_q     <= 4'd0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 16'd0;
      rsp_cout_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            last_q <= grant_d;
            id_q   <= grant_d;
            if (reject_d) begin
              // Error response is prepared now and raised on the next edge.
              state_q      <= RESP;
              rsp_id_q     <= grant_d;
              rsp_result_q <= 16'd0;
              rsp_cout_q   <= 1'b0;
              rsp_zero_q   <= 1'b0;
              rsp_err_q    <= 1'b1;
            end else begin
              state_q   <= EXEC;
              cnt_q     <= CNT_W'(ALU_LAT);
              alu_a_q   <= sel_a_d;
              alu_b_q   <= sel_b_d;
              alu_op_q  <= sel_op_d;
              alu_cin_q <= sel_cin_d;
            end
          end
        end

        EXEC: begin
          if (cnt_q == '0) begin
            // ALU outputs have settled from the operands held since entry.
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_result_q <= alu_result;
            rsp_cout_q   <= alu_cout;
            rsp_zero_q   <= alu_zflag;
            rsp_err_q    <= 1'b0;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            alu_op_q     <= 4'd0;
            alu_cin_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q != IDLE);

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_cin    = alu_cin_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a registered one-cycle ALU model.
module tb_alu_req_arbiter;

  logic        CLK;
  logic        Reset;
  logic        req0_valid, req0_ready, req0_cin;
  logic [7:0]  req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready, req1_cin;
  logic [7:0]  req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero, rsp_err, busy;
  logic [15:0] rsp_result;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic        alu_cout, alu_zflag;

  int n_chk  = 0;
  int n_pass = 0;

  alu_req_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zflag(alu_zflag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU model: {cout, result}
  function automatic logic [16:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op, input logic c);
    logic [8:0]  s;
    logic [15:0] r;
    logic        co;
    s  = 9'd0;
    r  = 16'd0;
    co = 1'b0;
    case (op)
      4'd0: begin
        s  = {1'b0, a} + {1'b0, b} + {8'd0, c};
        r  = {7'd0, s};
        co = s[8];
      end
      4'd1: begin
        s  = {1'b0, a} - {1'b0, b} - {8'd0, c};
        r  = {8'd0, s[7:0]};
        co = s[8];
      end
      4'd2: r = {8'd0, a} * {8'd0, b};
      4'd3: if (b != 8'd0) r = {a % b, a / b};
      4'd4: r = {8'd0, a & b};
      4'd5: r = {8'd0, a | b};
      default: r = 16'd0;
    endcase
    return {co, r};
  endfunction

  always @(posedge CLK) begin
    logic [16:0] f;
    f = alu_f(alu_a, alu_b, alu_op, alu_cin);
    alu_result <= f[15:0];
    alu_cout   <= f[16];
    alu_zflag  <= (f[15:0] == 16'd0);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request, wait (bounded) for ready, return just after the acceptance edge.
  task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic c);
    int n;
    n = 0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_cin = c;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_cin = c;
    end
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
    tick();
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  initial begin
    int         got;
    int         dbl;
    logic       ids  [4];
    logic [15:0] res [4];
    int         cyc  [4];

    Reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = 8'd0; req0_b = 8'd0; req0_op = 4'd0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_op = 4'd0; req1_cin = 1'b0;
    tick(); tick();

    // reset state
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    Reset = 1'b0;
    #1;
    check("idle_ready0", 32'(req0_ready), 32'd1);
    check("idle_ready1", 32'(req1_ready), 32'd0);

    // 1: add with carry, latency 2
    rsp_ready = 1'b1;
    issue(1'b0, 8'hFF, 8'h01, 4'd0, 1'b1);
    check("t1_alu_a", 32'(alu_a), 32'hFF);
    check("t1_alu_cin", 32'(alu_cin), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_valid_e0", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_valid_e1", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_valid_e2", 32'(rsp_valid), 32'd1);
    check("t1_result", 32'(rsp_result), 32'h0101);
    check("t1_cout", 32'(rsp_cout), 32'd1);
    check("t1_zero", 32'(rsp_zero), 32'd0);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_err", 32'(rsp_err), 32'd0);
    tick();
    check("t1_valid_done", 32'(rsp_valid), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd0);

    // 2: multiply from req1, ALU drive window
    issue(1'b1, 8'd200, 8'd200, 4'd2, 1'b0);
    check("t2_alu_a_c0", 32'(alu_a), 32'hC8);
    check("t2_alu_op_c0", 32'(alu_op), 32'd2);
    tick();
    check("t2_alu_b_c1", 32'(alu_b), 32'hC8);
    check("t2_alu_op_c1", 32'(alu_op), 32'd2);
    tick();
    check("t2_alu_a_after", 32'(alu_a), 32'd0);
    check("t2_alu_op_after", 32'(alu_op), 32'd0);
    check("t2_valid", 32'(rsp_valid), 32'd1);
    check("t2_result", 32'(rsp_result), 32'h9C40);
    check("t2_zero", 32'(rsp_zero), 32'd0);
    check("t2_id", 32'(rsp_id), 32'd1);
    tick();

    // 3: both valid continuously, round-robin order and spacing
    req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 4'd4; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h30; req1_op = 4'd5; req1_cin = 1'b0;
    got = 0;
    dbl = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      if (req0_ready && req1_ready) dbl++;
      if (rsp_valid && rsp_ready) begin
        ids[got] = rsp_id;
        res[got] = rsp_result;
        cyc[got] = c;
        got++;
      end
      if (got < 4) tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t3_count", 32'(got), 32'd4);
    check("t3_one_ready", 32'(dbl), 32'd0);
    if (got == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t3_id", 32'(ids[i]), 32'(i % 2));
        check("t3_result", 32'(res[i]), (i % 2 == 0) ? 32'h30 : 32'h3F);
      end
      check("t3_spacing", 32'(cyc[3] - cyc[2]), 32'd4);
    end
    tick();

    // 4: rejected ops answer one edge after acceptance, ALU untouched
    issue(1'b1, 8'd5, 8'd0, 4'd3, 1'b0);
    check("t4a_alu_op", 32'(alu_op), 32'd0);
    check("t4a_valid_e0", 32'(rsp_valid), 32'd0);
    tick();
    check("t4a_valid_e1", 32'(rsp_valid), 32'd1);
    check("t4a_err", 32'(rsp_err), 32'd1);
    check("t4a_result", 32'(rsp_result), 32'd0);
    check("t4a_id", 32'(rsp_id), 32'd1);
    check("t4a_alu_op_e1", 32'(alu_op), 32'd0);
    tick();
    issue(1'b1, 8'd1, 8'd2, 4'd7, 1'b1);
    check("t4b_alu_op", 32'(alu_op), 32'd0);
    tick();
    check("t4b_valid", 32'(rsp_valid), 32'd1);
    check("t4b_err", 32'(rsp_err), 32'd1);
    check("t4b_result", 32'(rsp_result), 32'd0);
    check("t4b_cout", 32'(rsp_cout), 32'd0);
    tick();

    // 5: back-pressure freezes the response and blocks grants
    rsp_ready = 1'b0;
    issue(1'b0, 8'd3, 8'd4, 4'd0, 1'b0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("t5_valid", 32'(rsp_valid), 32'd1);
      check("t5_result", 32'(rsp_result), 32'd7);
      check("t5_ready_any", 32'({req0_ready, req1_ready}), 32'd0);
      check("t5_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("t5_rr_ready1", 32'(req1_ready), 32'd1);
    check("t5_rr_ready0", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // 6: reset mid-EXEC discards the operation and restores the pointer
    issue(1'b0, 8'd1, 8'd1, 4'd0, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t6_valid", 32'(rsp_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_alu_a", 32'(alu_a), 32'd0);
    req0_valid = 1'b1; req0_a = 8'd2; req0_b = 8'd3; req0_op = 4'd0; req0_cin = 1'b0;
    req1_valid = 1'b1;
    #1;
    check("t6_ready0", 32'(req0_ready), 32'd1);
    check("t6_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick(); tick();
    check("t6_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t6_rsp_id", 32'(rsp_id), 32'd0);
    check("t6_rsp_result", 32'(rsp_result), 32'd5);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
